// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: a + b + cin over WIDTH/CHUNK cycles, with a start/done handshake.
// Optional feature macro: ADD_SUB_EN adds a 'sub' port so the same datapath can compute a + ~b + cin.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be at least 2");
        end
        if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
            $error("seq_chunk_adder: CHUNK must be in 1..WIDTH");
        end
        if (CHUNK >= 1 && (WIDTH % CHUNK) != 0) begin : g_bad_ratio
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [WIDTH-1:0] s_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_cap;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] s_next;
    logic             last;

`ifdef ADD_SUB_EN
    // Subtraction reuses the adder: invert B on capture, caller supplies cin=1.
    assign b_cap = sub ? ~b : b;
`else
    assign b_cap = b;
`endif

    assign chunk_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_r};
    assign last      = (cnt == CW'(N - 1));

    // New chunk enters at the top so after N shifts bit 0 holds the lowest chunk.
    generate
        if (CHUNK == WIDTH) begin : g_full
            assign s_next = chunk_sum[CHUNK-1:0];
        end else begin : g_part
            assign s_next = {chunk_sum[CHUNK-1:0], s_r[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            s_r   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b_cap;
                        c_r   <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r <= a_r >> CHUNK;
                    b_r <= b_r >> CHUNK;
                    c_r <= chunk_sum[CHUNK];
                    s_r <= s_next;
                    cnt <= cnt + CW'(1);
                    // Outputs are only updated here so no partial result is ever visible.
                    if (last) begin
                        sum   <= s_next;
                        cout  <= chunk_sum[CHUNK];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
